// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues word-aligned fetch requests under a credit limit, buffers in-order
// responses with their addresses, and presents the buffer head to the decoder.
// A redirect flushes the buffer, discards responses still in flight and
// restarts fetch; a misaligned redirect target parks the unit in FAULT until
// an aligned redirect arrives.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        fetch_fault
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [CW:0]   DEPTH_S  = (CW + 1)'(DEPTH);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } state_t;

   // Circular pointer advance; DEPTH need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // Clear the byte-offset bits of a fetch target.
   function automatic logic [31:0] align_word(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

   state_t        state_q;
   logic          fault_q;
   logic [31:0]   pc_q;        // next request address
   logic [31:0]   rsp_pc_q;    // address belonging to the next kept response
   logic [CW-1:0] inflight_q;
   logic [CW-1:0] drop_q;
   logic [CW-1:0] count_q;
   logic [PW-1:0] wptr_q;
   logic [PW-1:0] rptr_q;
   logic [31:0]   data_q [DEPTH];
   logic [31:0]   addr_q [DEPTH];

   logic [CW:0]   credit_used;
   logic          req_fire;
   logic          rsp_drop;
   logic          rsp_keep;
   logic          buf_full;
   logic          push;
   logic          pop;
   logic          tgt_misaligned;
   logic [31:0]   tgt_aligned;
   logic [CW-1:0] inflight_d;
   logic [CW-1:0] count_d;

   // Request credit, buffer handshakes and next-state counters.
   always_comb begin
      credit_used    = {1'b0, count_q} + {1'b0, inflight_q};
      // Stale responses must drain before refetching, so a new request
      // never shares the response stream with words still being dropped.
      imem_req_valid = !rst && (state_q == RUN) && !redirect &&
                       (drop_q == '0) && (credit_used < DEPTH_S);
      imem_req_addr  = pc_q;
      req_fire       = imem_req_valid && imem_req_ready;
      rsp_drop       = imem_rsp_valid && (drop_q != '0);
      rsp_keep       = imem_rsp_valid && (drop_q == '0) && (state_q == RUN);
      buf_full       = (count_q == DEPTH_C);
      pop            = (count_q != '0) && instr_ready;
      // Guard against overflow even though the credit rule prevents it.
      push           = rsp_keep && !redirect && (!buf_full || pop);
      tgt_misaligned = (redirect_pc[1:0] != 2'b00);
      tgt_aligned    = align_word(redirect_pc);
      inflight_d     = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
      count_d        = count_q + CW'(push) - CW'(pop);
   end

   // Decoder-facing view of the buffer head; zero when empty or in reset.
   always_comb begin
      instr_valid = !rst && (count_q != '0);
      instr       = instr_valid ? data_q[rptr_q] : 32'h0;
      instr_pc    = instr_valid ? addr_q[rptr_q] : 32'h0;
      fetch_fault = fault_q && !rst;
   end

   // Control state: FSM, pc tracking, credit counters and buffer pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         fault_q    <= 1'b0;
         pc_q       <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
         count_q    <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
      end else begin
         inflight_q <= inflight_d;
         if (redirect) begin
            // Everything still outstanding after this cycle belongs to the
            // old path and is discarded as it returns.
            drop_q   <= inflight_d;
            pc_q     <= tgt_aligned;
            rsp_pc_q <= tgt_aligned;
            count_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            if (tgt_misaligned) begin
               state_q <= FAULT;
               fault_q <= 1'b1;
            end else begin
               state_q <= RUN;
               fault_q <= 1'b0;
            end
         end else begin
            if (req_fire) begin
               pc_q <= pc_q + 32'd4;
            end
            if (rsp_drop) begin
               drop_q <= drop_q - CW'(1);
            end
            if (push) begin
               rsp_pc_q <= rsp_pc_q + 32'd4;
               wptr_q   <= ptr_inc(wptr_q);
            end
            if (pop) begin
               rptr_q <= ptr_inc(rptr_q);
            end
            count_q <= count_d;
         end
      end
   end

   // Buffer storage; contents are qualified by count_q so need no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wptr_q] <= imem_rsp_data;
         addr_q[wptr_q] <= rsp_pc_q;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a randomized in-order
// memory model and an expected-instruction-stream reference model.
module tb_fetch_unit;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        fetch_fault;

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .fetch_fault    (fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Memory contents: a fixed scramble of the address.
   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // ---------------- memory model ----------------
   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mq[$];
   int          cyc     = 0;
   int          rdy_pct = 100;
   int          rsp_pct = 100;
   int          lat_min = 1;
   int          lat_max = 1;
   int          acc_cnt = 0;
   logic        prev_pend;
   logic [31:0] prev_addr;

   initial begin
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      prev_pend      = 1'b0;
      prev_addr      = 32'h0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            mq.delete();
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'b0;
         end else begin
            imem_req_ready = ($urandom_range(99) < rdy_pct);
            if (mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = word_of(mq[0].addr);
               void'(mq.pop_front());
            end else begin
               imem_rsp_valid = 1'b0;
               imem_rsp_data  = $urandom;
            end
         end
         #3;
         // An offered request that was not taken must be held unless redirected.
         if (prev_pend && !rst && !redirect) begin
            check("req_hold_valid", 32'(imem_req_valid), 32'd1);
            check("req_hold_addr", imem_req_addr, prev_addr);
         end
         prev_pend = !rst && imem_req_valid && !imem_req_ready;
         prev_addr = imem_req_addr;
         if (!rst && imem_req_valid && imem_req_ready) begin
            mq.push_back('{imem_req_addr, cyc + int'($urandom_range(lat_max, lat_min))});
            acc_cnt++;
         end
         cyc++;
      end
   end

   // ---------------- reference model / scoreboard ----------------
   logic [31:0] exp_q[$];
   logic [31:0] exp_next;
   bit          exp_live;
   bit          exp_fault;
   int          consumed = 0;
   logic [31:0] last_pc  = 32'h0;

   // Monitor: one sample per cycle just before the rising edge.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         #4;
         check("fault_flag", 32'(fetch_fault), 32'(exp_fault));
         check("buf_bound", 32'(dut.count_q <= DEPTH), 32'd1);
         if (fetch_fault) begin
            check("fault_no_req", 32'(imem_req_valid), 32'd0);
            check("fault_no_instr", 32'(instr_valid), 32'd0);
         end
         if (!instr_valid) begin
            check("idle_instr", instr, 32'h0);
            check("idle_pc", instr_pc, 32'h0);
         end else if (instr_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_instr: got pc %h, none expected", instr_pc);
            end else begin
               e = exp_q.pop_front();
               check("instr_pc", instr_pc, e);
               check("instr_data", instr, word_of(e));
            end
            consumed++;
            last_pc = instr_pc;
         end
      end
   end

   task automatic topup();
      if (exp_live) begin
         while (exp_q.size() < 32) begin
            exp_q.push_back(exp_next);
            exp_next += 32'd4;
         end
      end
   endtask

   task automatic tick();
      topup();
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      rst       = 1'b1;
      redirect  = 1'b0;
      exp_q.delete();
      exp_live  = 1'b0;
      exp_fault = 1'b0;
      for (int i = 0; i < n; i++) begin
         #4;
         check("rst_req_valid", 32'(imem_req_valid), 32'd0);
         check("rst_instr_valid", 32'(instr_valid), 32'd0);
         check("rst_instr", instr, 32'h0);
         check("rst_instr_pc", instr_pc, 32'h0);
         check("rst_fault", 32'(fetch_fault), 32'd0);
         @(negedge clk);
      end
      rst      = 1'b0;
      exp_next = RESET_PC;
      exp_live = 1'b1;
      #4;
      check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
      check("post_rst_req_addr", imem_req_addr, RESET_PC);
      tick();
   endtask

   task automatic do_redirect(input logic [31:0] tgt);
      redirect    = 1'b1;
      redirect_pc = tgt;
      @(posedge clk);
      #1;
      exp_q.delete();
      if (tgt[1:0] == 2'b00) begin
         exp_live  = 1'b1;
         exp_next  = tgt;
         exp_fault = 1'b0;
      end else begin
         exp_live  = 1'b0;
         exp_fault = 1'b1;
      end
      @(negedge clk);
      redirect    = 1'b0;
      redirect_pc = $urandom;
   endtask

   task automatic wait_consume(input int n, input logic [31:0] exp_pc, input string name);
      int start;
      int k;
      start = consumed;
      k     = 0;
      while (consumed < start + n && k < 100) begin
         tick();
         k++;
      end
      check({name, "_progress"}, 32'(consumed >= start + n), 32'd1);
      check(name, last_pc, exp_pc);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          a0;
      int          k;
      int          r;
      logic [31:0] t;
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = 1'b0;
      exp_live    = 1'b0;
      exp_fault   = 1'b0;
      exp_next    = RESET_PC;
      @(negedge clk);

      // Streaming start-up: ideal memory, decoder always ready.
      instr_ready = 1'b1;
      do_reset(3);
      tick();
      #4;
      check("startup_valid", 32'(instr_valid), 32'd1);
      check("startup_pc", instr_pc, RESET_PC);
      @(negedge clk);
      wait_consume(2, 32'h8, "seq_third");

      // Decoder stall: credit limit caps outstanding fetches.
      instr_ready = 1'b0;
      a0 = acc_cnt;
      do_reset(2);
      repeat (10) tick();
      check("stall_reqs", 32'(acc_cnt - a0), 32'(DEPTH));
      #4;
      check("stall_head_valid", 32'(instr_valid), 32'd1);
      check("stall_head_pc", instr_pc, 32'h0);
      @(negedge clk);
      instr_ready = 1'b1;
      wait_consume(3, 32'h8, "stall_release");

      // Redirect with two responses outstanding.
      lat_min = 3;
      lat_max = 3;
      k = 0;
      while (mq.size() < 2 && k < 50) begin
         tick();
         k++;
      end
      check("two_inflight", 32'(mq.size() >= 2), 32'd1);
      do_redirect(32'h0000_0100);
      wait_consume(1, 32'h0000_0100, "redirect_first");

      // Misaligned target faults; aligned target recovers.
      do_redirect(32'h0000_0102);
      #4;
      check("fault_set", 32'(fetch_fault), 32'd1);
      check("fault_req_off", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
      repeat (4) tick();
      do_redirect(32'h0000_0200);
      #4;
      check("fault_clear", 32'(fetch_fault), 32'd0);
      @(negedge clk);
      wait_consume(1, 32'h0000_0200, "recover_first");

      // Address wrap at the top of the space.
      lat_min = 1;
      lat_max = 1;
      do_redirect(32'hFFFF_FFF8);
      wait_consume(3, 32'h0000_0000, "wrap");

      // Reset with a full buffer.
      instr_ready = 1'b0;
      lat_min = 2;
      lat_max = 2;
      repeat (6) tick();
      do_reset(1);
      instr_ready = 1'b1;
      wait_consume(2, 32'h0000_0004, "refetch");

      // Randomized traffic.
      lat_min = 1;
      lat_max = 4;
      rdy_pct = 70;
      rsp_pct = 75;
      for (int i = 0; i < 3000; i++) begin
         instr_ready = ($urandom_range(99) < 70);
         r = $urandom_range(999);
         if (r < 4) begin
            do_reset(1 + $urandom_range(1));
         end else if (r < 34) begin
            t = $urandom;
            if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            if ($urandom_range(5) == 0) t[31:8] = 24'hFF_FFFF;
            do_redirect(t);
         end else begin
            tick();
         end
      end
      instr_ready = 1'b1;
      rdy_pct = 100;
      rsp_pct = 100;
      repeat (20) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
      $fatal(1, "watchdog");
   end

endmodule
